// File: rtl/cla_addsub_pipe_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
// The S1 payload is sized for the widest legal operand; narrower builds leave the upper bits at zero.
package cla_addsub_pipe_pkg;

    localparam int CLA_WIDTH      = 32;
    localparam int CLA_GROUP      = 4;
    localparam int CLA_MAX_WIDTH  = 64;
    localparam int CLA_MAX_GROUPS = CLA_MAX_WIDTH / CLA_GROUP;

    typedef struct packed {
        logic [CLA_MAX_WIDTH-1:0]  p;
        logic [CLA_MAX_WIDTH-1:0]  g;
        logic [CLA_MAX_GROUPS-1:0] grp_g;
        logic [CLA_MAX_GROUPS-1:0] grp_p;
        logic                      cin;
`ifdef CLA_OVF_FLAGS_EN
        logic                      a_msb;
        logic                      b_msb;
`endif
    } cla_s1_t;

    function automatic int cla_num_groups(input int width);
        return width / CLA_GROUP;
    endfunction

endpackage

// File: rtl/cla_group_pg.sv
// One 4-bit lookahead group: bit/group generate-propagate from the operands (S1 side)
// and bit carries expanded from the group carry-in using the registered terms (S2 side).
module cla_group_pg
    import cla_addsub_pipe_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a_i,
    input  logic [CLA_GROUP-1:0] b_i,
    output logic [CLA_GROUP-1:0] g_o,
    output logic [CLA_GROUP-1:0] p_o,
    output logic                 grp_g_o,
    output logic                 grp_p_o,
    input  logic [CLA_GROUP-1:0] g_q_i,
    input  logic [CLA_GROUP-1:0] p_q_i,
    input  logic                 c_i,
    output logic [CLA_GROUP-1:0] c_o
);

    assign g_o = a_i & b_i;
    assign p_o = a_i ^ b_i;

    assign grp_g_o = g_o[3]
                   | (p_o[3] & g_o[2])
                   | (p_o[3] & p_o[2] & g_o[1])
                   | (p_o[3] & p_o[2] & p_o[1] & g_o[0]);
    assign grp_p_o = &p_o;

    assign c_o[0] = c_i;
    assign c_o[1] = g_q_i[0] | (p_q_i[0] & c_i);
    assign c_o[2] = g_q_i[1] | (p_q_i[1] & g_q_i[0]) | (p_q_i[1] & p_q_i[0] & c_i);
    assign c_o[3] = g_q_i[2] | (p_q_i[2] & g_q_i[1]) | (p_q_i[2] & p_q_i[1] & g_q_i[0])
                  | (p_q_i[2] & p_q_i[1] & p_q_i[0] & c_i);

    // The top bit's terms only feed the group carry-out, which the top resolves itself.
    logic unused_msb;
    assign unused_msb = g_q_i[3] ^ p_q_i[3];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Optional ovf/zero/neg flags are built when CLA_OVF_FLAGS_EN is defined.
module cla_addsub_pipe
    import cla_addsub_pipe_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVF_FLAGS_EN
   ,output logic             ovf,
    output logic             zero,
    output logic             neg
`endif
);

    localparam int NG = cla_num_groups(WIDTH);

    if ((WIDTH % CLA_GROUP) != 0 || WIDTH < 8 || WIDTH > CLA_MAX_WIDTH) begin : g_bad_width
        $error("cla_addsub_pipe: WIDTH must be a multiple of 4 in 8..64");
    end

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    cla_s1_t          s1_q, s1_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             s2_load, s1_adv, in_fire;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] bit_g, bit_p, bit_c;
    logic [NG-1:0]    grp_g, grp_p;
    logic [NG:0]      c_grp;

    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign s1_adv   = s1_valid_q && s2_load;

    assign s1_valid_d = in_fire ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
    assign s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;

    assign b_eff = sub ? ~b : b;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla_group_pg u_grp (
            .a_i     (a[gi*CLA_GROUP +: CLA_GROUP]),
            .b_i     (b_eff[gi*CLA_GROUP +: CLA_GROUP]),
            .g_o     (bit_g[gi*CLA_GROUP +: CLA_GROUP]),
            .p_o     (bit_p[gi*CLA_GROUP +: CLA_GROUP]),
            .grp_g_o (grp_g[gi]),
            .grp_p_o (grp_p[gi]),
            .g_q_i   (s1_q.g[gi*CLA_GROUP +: CLA_GROUP]),
            .p_q_i   (s1_q.p[gi*CLA_GROUP +: CLA_GROUP]),
            .c_i     (c_grp[gi]),
            .c_o     (bit_c[gi*CLA_GROUP +: CLA_GROUP])
        );
    end

    always_comb begin
        s1_d                  = '0;
        s1_d.p[WIDTH-1:0]     = bit_p;
        s1_d.g[WIDTH-1:0]     = bit_g;
        s1_d.grp_g[NG-1:0]    = grp_g;
        s1_d.grp_p[NG-1:0]    = grp_p;
        s1_d.cin              = sub;
`ifdef CLA_OVF_FLAGS_EN
        s1_d.a_msb            = a[WIDTH-1];
        s1_d.b_msb            = b_eff[WIDTH-1];
`endif
    end

    // Each group carry is a flat sum of products over all lower groups, not a ripple chain.
    assign c_grp[0] = s1_q.cin;
    for (genvar gi = 0; gi < NG; gi++) begin : g_ctree
        logic carry, term;
        always_comb begin
            term  = 1'b0;
            carry = s1_q.cin & (&s1_q.grp_p[gi:0]);
            for (int j = 0; j <= gi; j++) begin
                term = s1_q.grp_g[j];
                for (int m = j + 1; m <= gi; m++) begin
                    term = term & s1_q.grp_p[m];
                end
                carry = carry | term;
            end
        end
        assign c_grp[gi+1] = carry;
    end

    assign sum_d  = s1_q.p[WIDTH-1:0] ^ bit_c;
    assign cout_d = c_grp[NG];

    if (WIDTH < CLA_MAX_WIDTH) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^{s1_q.p[CLA_MAX_WIDTH-1:WIDTH], s1_q.g[CLA_MAX_WIDTH-1:WIDTH],
                             s1_q.grp_g[CLA_MAX_GROUPS-1:NG], s1_q.grp_p[CLA_MAX_GROUPS-1:NG]};
    end

`ifdef CLA_OVF_FLAGS_EN
    logic ovf_q, zero_q, neg_q;
    logic ovf_d, zero_d, neg_d;
    assign ovf_d  = (s1_q.a_msb == s1_q.b_msb) && (sum_d[WIDTH-1] != s1_q.a_msb);
    assign zero_d = (sum_d == '0);
    assign neg_d  = sum_d[WIDTH-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
`ifdef CLA_OVF_FLAGS_EN
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_fire) begin
                s1_q <= s1_d;
            end
            if (s1_adv) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
`ifdef CLA_OVF_FLAGS_EN
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
                neg_q  <= neg_d;
`endif
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CLA_OVF_FLAGS_EN
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign neg  = neg_q;
`endif

endmodule
